// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register file: response codes and the
// write/read channel state encodings.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_AW,
    W_HAVE_W,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_t;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Maps a bus address to a register index, plus in-range and read-only flags.
// Address bits below the word offset are ignored.
module axi_lite_addr_decode #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic [ADDRESS_WIDTH-1:0]    addr,
  output logic [$clog2(NUM_REGS)-1:0] index,
  output logic                        in_range,
  output logic                        read_only
);

  localparam int LSB   = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W = $clog2(NUM_REGS);

  assign index     = addr[LSB +: IDX_W];
  // Any set bit above the index field lands outside the register window.
  assign in_range  = (addr >> (LSB + IDX_W)) == '0;
  assign read_only = RO_MASK[index];

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave exposing NUM_REGS registers with byte strobes, per-register
// read-only overlay from ro_i, and fully registered channel outputs.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32,
  parameter int NUM_REGS      = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_o,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_i
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs   [NUM_REGS];
  logic [DATA_WIDTH-1:0] ro_arr [NUM_REGS];

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_o[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
    assign ro_arr[i] = ro_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  w_state_t w_state;
  r_state_t r_state;

  logic aw_hs, w_hs, ar_hs, wr_fire;
  logic [ADDRESS_WIDTH-1:0] aw_addr_q, wr_addr;
  logic [DATA_WIDTH-1:0]    wdata_q, wr_data;
  logic [STRB_W-1:0]        wstrb_q, wr_strb;
  logic [IDX_W-1:0]         wr_idx, rd_idx;
  logic                     wr_in_range, wr_ro, rd_in_range, rd_ro;
  resp_t                    wr_resp, rd_resp;
  logic [DATA_WIDTH-1:0]    rd_data;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // A channel that handshakes on the completing edge is taken live; the
  // other one comes from the holding registers.
  assign wr_addr = aw_hs ? AWADDR : aw_addr_q;
  assign wr_data = w_hs ? WDATA : wdata_q;
  assign wr_strb = w_hs ? WSTRB : wstrb_q;

  axi_lite_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_aw_decode (
    .addr(wr_addr), .index(wr_idx), .in_range(wr_in_range), .read_only(wr_ro)
  );

  axi_lite_addr_decode #(
    .DATA_WIDTH(DATA_WIDTH), .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) u_ar_decode (
    .addr(ARADDR), .index(rd_idx), .in_range(rd_in_range), .read_only(rd_ro)
  );

  always_comb begin
    wr_fire = 1'b0;
    case (w_state)
      W_IDLE:    wr_fire = aw_hs && w_hs;
      W_HAVE_AW: wr_fire = w_hs;
      W_HAVE_W:  wr_fire = aw_hs;
      default:   wr_fire = 1'b0;
    endcase
  end

  always_comb begin
    wr_resp = OKAY;
    if (!wr_in_range)
      wr_resp = DECERR;
    else if (wr_ro)
      wr_resp = SLVERR;
  end

  always_comb begin
    rd_resp = OKAY;
    rd_data = '0;
    if (!rd_in_range)
      rd_resp = DECERR;
    else if (rd_ro)
      rd_data = ro_arr[rd_idx];
    else
      rd_data = regs[rd_idx];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= OKAY;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      if (aw_hs)
        aw_addr_q <= AWADDR;
      if (w_hs) begin
        wdata_q <= WDATA;
        wstrb_q <= WSTRB;
      end
      case (w_state)
        W_IDLE: begin
          if (wr_fire) begin
            w_state <= W_RESP;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= wr_resp;
          end else if (aw_hs) begin
            w_state <= W_HAVE_AW;
            AWREADY <= 1'b0;
            WREADY  <= 1'b1;
          end else if (w_hs) begin
            w_state <= W_HAVE_W;
            AWREADY <= 1'b1;
            WREADY  <= 1'b0;
          end else begin
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        W_HAVE_AW, W_HAVE_W: begin
          if (wr_fire) begin
            w_state <= W_RESP;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b1;
            BRESP   <= wr_resp;
          end
        end
        W_RESP: begin
          if (BREADY) begin
            w_state <= W_IDLE;
            BVALID  <= 1'b0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Erroring writes (read-only or out of range) never touch storage.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_fire && wr_resp == OKAY) begin
      for (int b = 0; b < STRB_W; b++)
        if (wr_strb[b])
          regs[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RRESP   <= OKAY;
      RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_state <= R_RESP;
            ARREADY <= 1'b0;
            RVALID  <= 1'b1;
            RDATA   <= rd_data;
            RRESP   <= rd_resp;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            r_state <= R_IDLE;
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: channel ordering, strobes, error
// responses, read-only overlay, read/write collision and reset mid-response.
module tb_axi_lite_regfile;
  import axi_lite_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [NR-1:0] ROM = 16'h0008;

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic [AW-1:0] AWADDR = '0;
  logic [2:0]    AWPROT = 3'b010;
  logic          AWVALID = 1'b0;
  logic          AWREADY;
  logic [DW-1:0] WDATA = '0;
  logic [3:0]    WSTRB = '0;
  logic          WVALID = 1'b0;
  logic          WREADY;
  logic [1:0]    BRESP;
  logic          BVALID;
  logic          BREADY = 1'b0;
  logic [AW-1:0] ARADDR = '0;
  logic [2:0]    ARPROT = 3'b101;
  logic          ARVALID = 1'b0;
  logic          ARREADY;
  logic [DW-1:0] RDATA;
  logic [1:0]    RRESP;
  logic          RVALID;
  logic          RREADY = 1'b0;
  logic [NR*DW-1:0] reg_o;
  logic [NR*DW-1:0] ro_i = '0;

  int n_cmp = 0;
  int n_fail = 0;

  axi_lite_regfile #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(ROM)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_o(reg_o), .ro_i(ro_i)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [DW-1:0] regAt(input int i);
    return reg_o[i*DW +: DW];
  endfunction

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    AWADDR = addr; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1;
    for (int n = 0; n < 20 && !(AWREADY && WREADY); n++) tick();
    checkOutput({tag, "_ready"}, 64'(AWREADY && WREADY), 64'd1);
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    checkOutput({tag, "_bvalid"}, 64'(BVALID), 64'd1);
    checkOutput({tag, "_bresp"}, 64'(BRESP), 64'(exp_resp));
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checkOutput({tag, "_bdone"}, 64'(BVALID), 64'd0);
  endtask

  task automatic applyRead(input logic [AW-1:0] addr, input logic [DW-1:0] exp_data,
                           input logic [1:0] exp_resp, input string tag);
    ARADDR = addr; ARVALID = 1'b1;
    for (int n = 0; n < 20 && !ARREADY; n++) tick();
    checkOutput({tag, "_arready"}, 64'(ARREADY), 64'd1);
    tick();
    ARVALID = 1'b0;
    checkOutput({tag, "_rvalid"}, 64'(RVALID), 64'd1);
    checkOutput({tag, "_rdata"}, 64'(RDATA), 64'(exp_data));
    checkOutput({tag, "_rresp"}, 64'(RRESP), 64'(exp_resp));
    RREADY = 1'b1;
    tick();
    RREADY = 1'b0;
    checkOutput({tag, "_rdone"}, 64'(RVALID), 64'd0);
  endtask

  initial begin
    $display("[TB] start");
    // Reset state and release.
    repeat (2) tick();
    checkOutput("rst_awready", 64'(AWREADY), 64'd0);
    checkOutput("rst_wready", 64'(WREADY), 64'd0);
    checkOutput("rst_arready", 64'(ARREADY), 64'd0);
    checkOutput("rst_bvalid", 64'(BVALID), 64'd0);
    checkOutput("rst_rvalid", 64'(RVALID), 64'd0);
    checkOutput("rst_rdata", 64'(RDATA), 64'd0);
    checkOutput("rst_regs", 64'(|reg_o), 64'd0);
    ARESETn = 1'b1;
    checkOutput("rel_awready_low", 64'(AWREADY), 64'd0);
    tick();
    checkOutput("rel_awready", 64'(AWREADY), 64'd1);
    checkOutput("rel_wready", 64'(WREADY), 64'd1);
    checkOutput("rel_arready", 64'(ARREADY), 64'd1);

    // Full-word write with AW and W together, then read back.
    applyWrite(32'h08, 32'hDEADBEEF, 4'hF, OKAY, "wr08");
    checkOutput("reg2", 64'(regAt(2)), 64'hDEADBEEF);
    applyRead(32'h08, 32'hDEADBEEF, OKAY, "rd08");

    // Byte strobes 0x5 update bytes 0 and 2 only.
    applyWrite(32'h04, 32'h11223344, 4'hF, OKAY, "wr04");
    applyWrite(32'h04, 32'hAABBCCDD, 4'h5, OKAY, "wr04_strb");
    checkOutput("reg1_strb", 64'(regAt(1)), 64'h11BB33DD);

    // Zero strobe is an OKAY no-op.
    applyWrite(32'h08, 32'h12345678, 4'h0, OKAY, "wr08_nostrb");
    checkOutput("reg2_nostrb", 64'(regAt(2)), 64'hDEADBEEF);

    // W two cycles ahead of AW, then B back-pressure.
    AWADDR = 32'h14; WDATA = 32'h0000CAFE; WSTRB = 4'hF; WVALID = 1'b1;
    tick();
    WVALID = 1'b0; WDATA = 32'h0BAD0BAD;
    checkOutput("hw_awready", 64'(AWREADY), 64'd1);
    checkOutput("hw_wready", 64'(WREADY), 64'd0);
    checkOutput("hw_bvalid", 64'(BVALID), 64'd0);
    tick();
    AWVALID = 1'b1;
    tick();
    AWVALID = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("bp_bvalid", 64'(BVALID), 64'd1);
      checkOutput("bp_awready", 64'(AWREADY), 64'd0);
      checkOutput("bp_wready", 64'(WREADY), 64'd0);
      tick();
    end
    checkOutput("bp_bresp", 64'(BRESP), 64'(OKAY));
    checkOutput("reg5", 64'(regAt(5)), 64'h0000CAFE);
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    checkOutput("bp_bdone", 64'(BVALID), 64'd0);
    checkOutput("bp_awready_back", 64'(AWREADY), 64'd1);
    checkOutput("bp_wready_back", 64'(WREADY), 64'd1);

    // Out-of-range accesses and the read-only register.
    applyRead(32'h40, 32'h0, DECERR, "rd40");
    applyWrite(32'h44, 32'hFFFFFFFF, 4'hF, DECERR, "wr44");
    checkOutput("reg1_after_decerr", 64'(regAt(1)), 64'h11BB33DD);
    applyWrite(32'h0C, 32'h12345678, 4'hF, SLVERR, "wr0c");
    checkOutput("reg3_ro", 64'(regAt(3)), 64'h0);
    ro_i[3*DW +: DW] = 32'h55;
    applyRead(32'h0C, 32'h55, OKAY, "rd0c");

    // Read and write to the same register on the same edge.
    applyWrite(32'h10, 32'h1, 4'hF, OKAY, "wr10_old");
    AWADDR = 32'h10; WDATA = 32'h2; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 32'h10; ARVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    checkOutput("col_rvalid", 64'(RVALID), 64'd1);
    checkOutput("col_rdata", 64'(RDATA), 64'h1);
    checkOutput("col_bvalid", 64'(BVALID), 64'd1);
    checkOutput("col_reg4", 64'(regAt(4)), 64'h2);
    BREADY = 1'b1; RREADY = 1'b1;
    tick();
    BREADY = 1'b0; RREADY = 1'b0;
    applyRead(32'h10, 32'h2, OKAY, "rd10_new");

    // Reset while a write response is pending.
    AWADDR = 32'h18; WDATA = 32'h77; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    tick();
    AWVALID = 1'b0; WVALID = 1'b0;
    checkOutput("mr_bvalid_pre", 64'(BVALID), 64'd1);
    checkOutput("mr_reg6_pre", 64'(regAt(6)), 64'h77);
    #2;
    ARESETn = 1'b0;
    #1;
    checkOutput("mr_bvalid", 64'(BVALID), 64'd0);
    checkOutput("mr_awready", 64'(AWREADY), 64'd0);
    checkOutput("mr_regs", 64'(|reg_o), 64'd0);
    tick();
    ARESETn = 1'b1;
    tick();
    checkOutput("mr_bvalid_after", 64'(BVALID), 64'd0);
    applyWrite(32'h18, 32'h99, 4'hF, OKAY, "wr18_after");
    checkOutput("reg6_after", 64'(regAt(6)), 64'h99);
    checkOutput("reg2_after", 64'(regAt(2)), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_regfile.md
AXI_LITE_REGFILE -- requirements
Module: axi_lite_regfile

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning bus data width; legal values are 32 and 64.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, meaning bus address width.
REQ-003 SHALL have parameter NUM_REGS, default 16, meaning register count; it is a power of two, 2..256.
REQ-004 SHALL have parameter RO_MASK, default 0, NUM_REGS bits, meaning bit i=1 makes register i read-only (value sourced from ro_i).
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports follow.
REQ-006 ACLK  input  1  clock; all logic on the rising edge.
REQ-007 ARESETn  input  1  asynchronous active-low reset.
REQ-008 AWADDR/AWPROT/AWVALID input ADDRESS_WIDTH/3/1; AWREADY output 1: write-address channel.
REQ-009 WDATA/WSTRB/WVALID input DATA_WIDTH/DATA_WIDTH/8/1; WREADY output 1: write-data channel.
REQ-010 BRESP/BVALID output 2/1; BREADY input 1: write-response channel.
REQ-011 ARADDR/ARPROT/ARVALID input ADDRESS_WIDTH/3/1; ARREADY output 1: read-address channel.
REQ-012 RDATA/RRESP/RVALID output DATA_WIDTH/2/1; RREADY input 1: read-data channel.
REQ-013 reg_o  output  NUM_REGS*DATA_WIDTH  flattened current register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 ro_i  input  NUM_REGS*DATA_WIDTH  hardware values of read-only registers; same layout as reg_o.

Function
REQ-015 Register index SHALL be AxADDR[LSB +: log2(NUM_REGS)], where LSB=log2(DATA_WIDTH/8); address bits below LSB are ignored.
REQ-016 An address with any bit at or above LSB+log2(NUM_REGS) set SHALL be out of range and SHALL get DECERR (2'b11).
REQ-017 Write FSM states SHALL be W_IDLE, W_HAVE_AW, W_HAVE_W and W_RESP.
REQ-018 In W_IDLE, AWREADY=WREADY=1; AW-only -> W_HAVE_AW, W-only -> W_HAVE_W, both in the same cycle -> W_RESP.
REQ-019 In W_HAVE_AW only WREADY=1; in W_HAVE_W only AWREADY=1; the missing handshake -> W_RESP.
REQ-020 The register update SHALL occur on the edge entering W_RESP; BVALID SHALL rise the same edge (write latency 1 cycle after the last of AW/W).
REQ-021 The write SHALL update only the bytes whose WSTRB bit is 1; WSTRB=0 SHALL be a legal no-op that returns OKAY.
REQ-022 A write to an RO_MASK register SHALL be dropped with BRESP=SLVERR (2'b10); an out-of-range write SHALL be dropped with DECERR.
REQ-023 BVALID/BRESP SHALL hold until BREADY; on the handshake -> W_IDLE, with AWREADY/WREADY low throughout W_RESP.
REQ-024 Read FSM states SHALL be R_IDLE (ARREADY=1) and R_RESP (ARREADY=0).
REQ-025 On the AR handshake, RDATA/RRESP SHALL register the next cycle (latency 1) and hold, with RVALID=1, until RREADY, then -> R_IDLE.
REQ-026 RDATA SHALL be ro_i for RO registers, the stored value otherwise, and 0 with DECERR when out of range.
REQ-027 Read and write paths SHALL be independent; a read and write to the same register handshaking in the same cycle SHALL return the pre-write value.
REQ-028 AxPROT SHALL be accepted and ignored.
REQ-029 Outputs SHALL not depend combinationally on any VALID or READY input.

Reset
REQ-030 Asserting ARESETn low SHALL asynchronously force: all registers 0; AWREADY, WREADY, ARREADY, BVALID, RVALID = 0; BRESP, RRESP = 0; RDATA = 0; both FSMs to IDLE.
REQ-031 Ready outputs SHALL rise on the first rising ACLK after ARESETn deasserts.
REQ-032 Reset mid-transaction SHALL abandon the transaction without a response.

Structure
REQ-033 Package axi_lite_pkg SHALL hold the resp_t enum (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the write/read state typedefs.
REQ-034 Address decode (index, in-range, read-only flags) SHALL be one sub-module, axi_lite_addr_decode, instantiated twice (AW and AR).

Verification
REQ-035 Bench SHALL: write 0xDEADBEEF to 0x08 with WSTRB=0xF, AW and W in the same cycle -> BRESP=OKAY and reg_o[2]=0xDEADBEEF; then read 0x08 -> RDATA=0xDEADBEEF.
REQ-036 Bench SHALL: with reg 1 = 0x11223344, write 0xAABBCCDD to 0x04 with WSTRB=0x5 -> reg 1 = 0x11BB33DD.
REQ-037 Bench SHALL: W two cycles before AW, then BREADY held low 3 cycles -> BVALID stays 1, AWREADY=WREADY=0 until the B handshake.
REQ-038 Bench SHALL: NUM_REGS=16, read 0x40 -> RRESP=DECERR, RDATA=0; RO_MASK bit 3 set, write 0x0C -> SLVERR and reg 3 unchanged; ro_i[3]=0x55 -> read 0x0C gives 0x55.
REQ-039 Bench SHALL: same-cycle read and write to 0x10 (old 0x1, new 0x2) -> RDATA=0x1, then a later read -> 0x2.
REQ-040 Bench SHALL: assert ARESETn low while BVALID=1 -> BVALID=0 and all registers 0 immediately, then normal writes resume after release.
